// File: rtl/irq_encoder_148_pkg.sv
// ============================================================================
// irq_pkg : shared constants, FSM encoding and helpers for irq_encoder_148
// Revision: 1.0
// ============================================================================
`default_nettype none

package irq_pkg;

   localparam int IRQ_LINES = 8;
   localparam int IRQ_VEC_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      HOLD    = 2'd2
   } irq_state_e;

   function automatic logic [IRQ_LINES-1:0] vec_onehot(input logic [IRQ_VEC_W-1:0] v);
      logic [IRQ_LINES-1:0] oh;
      oh    = '0;
      oh[v] = 1'b1;
      return oh;
   endfunction

endpackage : irq_pkg

`default_nettype wire

// File: rtl/irq_encoder_148_prio.sv
// ============================================================================
// prio_enc_8 : combinational 8->3 priority encoder, highest set index wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module prio_enc_8
   import irq_pkg::*;
(
   input  logic [IRQ_LINES-1:0] lines,
   output logic                 any,
   output logic [IRQ_VEC_W-1:0] idx
);

   always_comb begin
      any = |lines;
      idx = '0;
      // Ascending scan so the highest set line overwrites lower ones.
      for (int i = 0; i < IRQ_LINES; i++) begin
         if (lines[i]) idx = IRQ_VEC_W'(i);
      end
   end

endmodule : prio_enc_8

`default_nettype wire

// File: rtl/irq_encoder_148.sv
// ============================================================================
// irq_encoder_148 : synchronised, masked, priority-encoded interrupt requests
// under a req/ack handshake. Optional mask register: IRQ_ENCODER_148_MASK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_encoder_148
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IRQ_LINES-1:0] nirq,
   input  logic                 ei,
   input  logic                 mask_we,
   input  logic [IRQ_LINES-1:0] mask_d,
   input  logic                 ack,
   output logic                 req,
   output logic [IRQ_VEC_W-1:0] vec,
   output logic [IRQ_LINES-1:0] pending,
   output logic [IRQ_LINES-1:0] mask
);

   logic [SYNC_STAGES-1:0][IRQ_LINES-1:0] sync_q, sync_d;
   logic [IRQ_LINES-1:0] prev_q, prev_d;
   logic [IRQ_LINES-1:0] pending_q, pending_d;
   logic [IRQ_LINES-1:0] mask_reg_q;
   logic [IRQ_LINES-1:0] fall, clr, eligible;
   logic [IRQ_VEC_W-1:0] vec_q, vec_d, enc_idx;
   logic                 req_q, req_d, enc_any;
   irq_state_e           state_q, state_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = nirq;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Falling edge of the synchronised line; a line held low requests once.
   assign prev_d = sync_q[SYNC_STAGES-1];
   assign fall   = prev_q & ~sync_q[SYNC_STAGES-1];

`ifdef IRQ_ENCODER_148_MASK_EN
   logic [IRQ_LINES-1:0] mask_reg_d;

   always_comb begin
      mask_reg_d = mask_reg_q;
      if (mask_we) mask_reg_d = mask_d;
   end

   always_ff @(posedge clk) begin
      if (reset) mask_reg_q <= '1;
      else       mask_reg_q <= mask_reg_d;
   end
`else
   logic unused_mask_in;

   assign mask_reg_q     = '1;
   assign unused_mask_in = ^{mask_we, mask_d};
`endif

   assign eligible = pending_q & mask_reg_q;

   prio_enc_8 u_prio (
      .lines (eligible),
      .any   (enc_any),
      .idx   (enc_idx)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      vec_d   = vec_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (ei && enc_any) begin
               vec_d   = enc_idx;
               req_d   = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (ack) begin
               clr     = vec_onehot(vec_q);
               req_d   = 1'b0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // A new edge on the line being acknowledged keeps it pending.
   assign pending_d = (pending_q & ~clr) | fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '1;
         prev_q    <= '1;
         pending_q <= '0;
         vec_q     <= '0;
         req_q     <= 1'b0;
         state_q   <= IDLE;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         vec_q     <= vec_d;
         req_q     <= req_d;
         state_q   <= state_d;
      end
   end

   assign req     = req_q;
   assign vec     = vec_q;
   assign pending = pending_q;
   assign mask    = mask_reg_q;

endmodule : irq_encoder_148

`default_nettype wire

// File: tb/tb_irq_encoder_148.sv
// ============================================================================
// tb_irq_encoder_148 : table-driven and sequence tests for irq_encoder_148
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_irq_encoder_148;

`ifdef IRQ_ENCODER_148_MASK_EN
   localparam logic MASK_ON = 1'b1;
`else
   localparam logic MASK_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] nirq = 8'hFF;
   logic       ei = 1'b1;
   logic       mask_we = 1'b0;
   logic [7:0] mask_d = 8'hFF;
   logic       ack = 1'b0;
   logic       req;
   logic [2:0] vec;
   logic [7:0] pending;
   logic [7:0] mask;

   int tests = 0;
   int fails = 0;
   logic [2:0] sb[$];

   irq_encoder_148 #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .nirq    (nirq),
      .ei      (ei),
      .mask_we (mask_we),
      .mask_d  (mask_d),
      .ack     (ack),
      .req     (req),
      .vec     (vec),
      .pending (pending),
      .mask    (mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] fall;
      logic [7:0] exp_pend;
      int         n;
      logic [2:0] v0;
      logic [2:0] v1;
      logic [2:0] v2;
   } vec_rec_t;

   vec_rec_t tbl[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic wait_req(input string nm, output int waited);
      int n;
      logic [2:0] e;
      n = 0;
      while (req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      waited = n;
      e = (sb.size() > 0) ? sb.pop_front() : 3'd0;
      if (req !== 1'b1) chk({nm, " req timeout"}, 32'(req), 32'd1);
      else              chk({nm, " vec"}, 32'(vec), 32'(e));
   endtask

   task automatic do_ack(input string nm);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk({nm, " req drop"}, 32'(req), 32'd0);
   endtask

   task automatic serve(input string nm, output int waited);
      wait_req(nm, waited);
      do_ack(nm);
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_d  = m;
      mask_we = 1'b1;
      tick();
      mask_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      tbl[0] = '{8'h04, 8'h04, 1, 3'd2, 3'd0, 3'd0};
      tbl[1] = '{8'h42, 8'h42, 2, 3'd6, 3'd1, 3'd0};
      tbl[2] = '{8'h81, 8'h81, 2, 3'd7, 3'd0, 3'd0};
      tbl[3] = '{8'h2C, 8'h2C, 3, 3'd5, 3'd3, 3'd2};
      tbl[4] = '{8'h10, 8'h10, 1, 3'd4, 3'd0, 3'd0};

      tick();
      tick();
      chk("reset req", 32'(req), 32'd0);
      chk("reset vec", 32'(vec), 32'd0);
      chk("reset pending", 32'(pending), 32'h00);
      chk("reset mask", 32'(mask), 32'hFF);
      reset = 1'b0;
      repeat (3) tick();

      // ack with nothing presented has no effect
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      chk("idle ack req", 32'(req), 32'd0);
      chk("idle ack pending", 32'(pending), 32'h00);

      for (int t = 0; t < 5; t++) begin
         nirq = ~tbl[t].fall;
         for (int k = 0; k < tbl[t].n; k++)
            sb.push_back(k == 0 ? tbl[t].v0 : (k == 1 ? tbl[t].v1 : tbl[t].v2));
         tick();
         tick();
         tick();
         chk($sformatf("t%0d pending@E2", t), 32'(pending), 32'(tbl[t].exp_pend));
         chk($sformatf("t%0d req@E2", t), 32'(req), 32'd0);
         tick();
         chk($sformatf("t%0d req@E3", t), 32'(req), 32'd1);
         for (int k = 0; k < tbl[t].n; k++) begin
            serve($sformatf("t%0d.%0d", t, k), w);
            chk($sformatf("t%0d.%0d latency", t, k), 32'(w), (k == 0) ? 32'd0 : 32'd2);
         end
         chk($sformatf("t%0d pending clear", t), 32'(pending), 32'h00);
         nirq = 8'hFF;
         repeat (4) tick();
         chk($sformatf("t%0d idle req", t), 32'(req), 32'd0);
      end

      // ei low blocks presentation
      ei   = 1'b0;
      nirq = 8'hFB;
      repeat (6) tick();
      chk("ei0 req", 32'(req), 32'd0);
      chk("ei0 pending", 32'(pending), 32'h04);
      ei = 1'b1;
      sb.push_back(3'd2);
      serve("ei1", w);
      nirq = 8'hFF;
      repeat (4) tick();

      // masked line 7 waits until the mask opens
      write_mask(8'h7F);
      chk("mask 7F", 32'(mask), MASK_ON ? 32'h7F : 32'hFF);
      nirq = 8'h7F;
      repeat (6) tick();
      chk("masked pending", 32'(pending), 32'h80);
      chk("masked req", 32'(req), MASK_ON ? 32'd0 : 32'd1);
      write_mask(8'hFF);
      sb.push_back(3'd7);
      serve("unmask", w);
      nirq = 8'hFF;
      repeat (4) tick();

      // vec frozen in PRESENT despite new edge, mask write and ei low
      nirq = 8'hF7;
      sb.push_back(3'd3);
      wait_req("freeze", w);
      nirq = 8'hD7;
      ei   = 1'b0;
      write_mask(8'h00);
      repeat (5) tick();
      chk("freeze vec", 32'(vec), 32'd3);
      chk("freeze req", 32'(req), 32'd1);
      ei = 1'b1;
      do_ack("freeze");
      if (MASK_ON) begin
         repeat (5) tick();
         chk("mask00 req", 32'(req), 32'd0);
         chk("mask00 pending", 32'(pending), 32'h20);
         write_mask(8'hFF);
      end else begin
         write_mask(8'hFF);
      end
      sb.push_back(3'd5);
      serve("line5", w);
      nirq = 8'hFF;
      repeat (4) tick();

      // new edge on the acked line in the ack cycle keeps it pending
      nirq = 8'hEF;
      sb.push_back(3'd4);
      wait_req("setwins first", w);
      nirq = 8'hFF;
      repeat (4) tick();
      nirq = 8'hEF;
      tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("setwins req drop", 32'(req), 32'd0);
      chk("setwins pending", 32'(pending), 32'h10);
      sb.push_back(3'd4);
      wait_req("setwins again", w);
      chk("setwins latency", 32'(w), 32'd2);
      do_ack("setwins again");
      chk("setwins clear", 32'(pending), 32'h00);
      nirq = 8'hFF;
      repeat (4) tick();

      // reset while presenting drops everything
      nirq = 8'hFC;
      sb.push_back(3'd1);
      wait_req("rst pre", w);
      write_mask(8'h0F);
      chk("mask 0F", 32'(mask), MASK_ON ? 32'h0F : 32'hFF);
      reset = 1'b1;
      nirq  = 8'hFF;
      tick();
      reset = 1'b0;
      chk("rst req", 32'(req), 32'd0);
      chk("rst pending", 32'(pending), 32'h00);
      chk("rst mask", 32'(mask), 32'hFF);
      chk("rst vec", 32'(vec), 32'd0);
      repeat (6) tick();
      chk("rst idle req", 32'(req), 32'd0);
      chk("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_irq_encoder_148

`default_nettype wire
